ct_clk_gate_ctrl: RTL and testbench



---
 rtl/ct_clk_pkg.sv | 22 ++
 rtl/ct_clk_icg_cell.sv | 23 ++
 rtl/ct_clk_gate_ctrl.sv | 121 ++++++++++++
 tb/tb_ct_clk_gate_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_clk_pkg.sv
// rtl/ct_clk_pkg.sv - shared types and constants for the core clock-gating controller
package ct_clk_pkg;

    // Per-domain gating FSM states
    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_HOLD = 3'd1,
        ST_QREQ = 3'd2,
        ST_OFF  = 3'd3,
        ST_WAKE = 3'd4
    } ct_state_e;

    // Default wakeup source indices into wake_src
    localparam int SRC_NORMAL = 0;
    localparam int SRC_INT    = 1;
    localparam int SRC_DBG    = 2;
    localparam int SRC_SNOOP  = 3;
    localparam int SRC_HAD    = 4;
    localparam int SRC_PMP    = 5;
    localparam int SRC_SPARE  = 6;

endpackage

// File: rtl/ct_clk_icg_cell.sv
// rtl/ct_clk_icg_cell.sv - glitch-free latch-based integrated clock gate
module ct_clk_icg_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic se_i,
    output logic gclk_o
);

    logic en_latched;

    // Capture enable only while the clock is low; reset forces the gate open
    always_latch begin
        if (rst_i) begin
            en_latched <= 1'b1;
        end else if (!clk_i) begin
            en_latched <= en_i | se_i;
        end
    end

    assign gclk_o = clk_i & en_latched;

endmodule

// File: rtl/ct_clk_gate_ctrl.sv
// rtl/ct_clk_gate_ctrl.sv - N-domain core clock-gating controller with quiesce handshake
module ct_clk_gate_ctrl
    import ct_clk_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int N_SRC    = 7,
    parameter logic [N_DOM*N_SRC-1:0] DOM_SRC_MAP = {N_DOM*N_SRC{1'b1}},
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic             pll_core_clk,
    input  logic             cpurst,
    input  logic [N_SRC-1:0] wake_src,
    input  logic             cp0_xx_core_icg_en,
    input  logic             had_xx_clk_en,
    input  logic [N_DOM-1:0] dom_idle_ack,
    output logic             forever_coreclk,
    output logic [N_DOM-1:0] dom_clk,
    output logic [N_DOM-1:0] dom_quiesce_req,
    output logic [N_DOM-1:0] dom_clk_on
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    // Counter compare values must fit the counter without wrapping
    if (HOLD_CYC < 1 || HOLD_CYC >= (1 << CNT_W)) begin : g_hold_range_err
        $error("ct_clk_gate_ctrl: HOLD_CYC out of range for CNT_W");
    end
    if (WAKE_CYC < 1 || WAKE_CYC >= (1 << CNT_W)) begin : g_wake_range_err
        $error("ct_clk_gate_ctrl: WAKE_CYC out of range for CNT_W");
    end

    assign forever_coreclk = pll_core_clk;

    for (genvar d = 0; d < N_DOM; d++) begin : g_dom
        ct_state_e        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             wake;
        logic             gate_en;

        // Force inputs share the normal wake path so they also honour wake settling
        assign wake = (|(wake_src & DOM_SRC_MAP[d*N_SRC +: N_SRC]))
                    | cp0_xx_core_icg_en | had_xx_clk_en;

        // State and hysteresis/settle counter; reset returns the domain to running
        always_ff @(posedge pll_core_clk or posedge cpurst) begin
            if (cpurst) begin
                state_q <= ST_RUN;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state: idle hysteresis, quiesce handshake, then wake settling
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_RUN: begin
                    if (!wake) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (wake) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_QREQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_QREQ: begin
                    // A late wake beats the ack so the domain is never gated under it
                    if (wake) begin
                        state_d = ST_RUN;
                    end else if (dom_idle_ack[d]) begin
                        state_d = ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (wake) begin
                        state_d = ST_WAKE;
                        cnt_d   = '0;
                    end
                end
                ST_WAKE: begin
                    // Settling always completes; a lost wake is handled from RUN
                    if (cnt_q == WAKE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        assign gate_en            = (state_q != ST_OFF);
        assign dom_clk_on[d]      = (state_q == ST_RUN) || (state_q == ST_HOLD)
                                 || (state_q == ST_QREQ);
        assign dom_quiesce_req[d] = (state_q == ST_QREQ);

        ct_clk_icg_cell u_icg (
            .clk_i  (pll_core_clk),
            .rst_i  (cpurst),
            .en_i   (gate_en),
            .se_i   (1'b0),
            .gclk_o (dom_clk[d])
        );
    end

endmodule

// File: tb/tb_ct_clk_gate_ctrl.sv
// tb/tb_ct_clk_gate_ctrl.sv - scoreboard bench for the core clock-gating controller
module tb_ct_clk_gate_ctrl;
    import ct_clk_pkg::*;

    localparam int ND = 4;
    localparam int NS = 7;
    localparam int HC = 16;
    localparam int WC = 2;
    // Source 3 (snoop) does not keep domain 2 awake: bit 2*7+3 = 17 cleared
    localparam logic [ND*NS-1:0] MAP = 28'hFFDFFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] wsrc = '0;
    logic          cp0 = 1'b0;
    logic          had = 1'b0;
    logic [ND-1:0] ack = '0;
    logic          fclk;
    logic [ND-1:0] dclk;
    logic [ND-1:0] dreq;
    logic [ND-1:0] don;

    ct_clk_gate_ctrl #(
        .N_DOM       (ND),
        .N_SRC       (NS),
        .DOM_SRC_MAP (MAP),
        .CNT_W       (8),
        .HOLD_CYC    (HC),
        .WAKE_CYC    (WC)
    ) dut (
        .pll_core_clk       (clk),
        .cpurst             (rst),
        .wake_src           (wsrc),
        .cp0_xx_core_icg_en (cp0),
        .had_xx_clk_en      (had),
        .dom_idle_ack       (ack),
        .forever_coreclk    (fclk),
        .dom_clk            (dclk),
        .dom_quiesce_req    (dreq),
        .dom_clk_on         (don)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] hi;
        logic [ND-1:0] on;
        logic [ND-1:0] req;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model: counts of consecutive idle samples and remaining settle cycles
    bit            m_off[ND];
    int            m_idle[ND];
    int            m_settle[ND];
    logic [ND*NS-1:0] map_v;

    bit glitch_win = 1'b0;
    int glitch_cnt = 0;

    always @(posedge dclk[2]) begin
        if (glitch_win) glitch_cnt++;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_total++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Drive one cycle of stimulus and queue what the next clock edge must produce
    task automatic step(input logic [NS-1:0] w, input logic [ND-1:0] a,
                        input logic c, input logic h, input logic r);
        exp_t e;
        logic [ND-1:0] dw;
        @(negedge clk);
        wsrc = w;
        ack  = a;
        cp0  = c;
        had  = h;
        rst  = r;
        for (int d = 0; d < ND; d++) begin
            e.hi[d] = r ? 1'b1 : !m_off[d];
            dw[d]   = (|(w & map_v[d*NS +: NS])) | c | h;
        end
        for (int d = 0; d < ND; d++) begin
            if (r) begin
                m_off[d] = 1'b0; m_settle[d] = 0; m_idle[d] = 0;
            end else if (m_off[d]) begin
                if (dw[d]) begin
                    m_off[d] = 1'b0; m_settle[d] = WC; m_idle[d] = 0;
                end
            end else if (m_settle[d] > 0) begin
                m_settle[d]--;
            end else if (dw[d]) begin
                m_idle[d] = 0;
            end else if (m_idle[d] > HC && a[d]) begin
                m_off[d] = 1'b1;
            end else if (m_idle[d] < 1000) begin
                m_idle[d]++;
            end
        end
        for (int d = 0; d < ND; d++) begin
            e.on[d]  = !m_off[d] && (m_settle[d] == 0);
            e.req[d] = e.on[d] && (m_idle[d] > HC);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare each clock edge's outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dom_clk_high", dclk, e.hi);
                chk("dom_clk_on", don, e.on);
                chk("quiesce_req", dreq, e.req);
                chk("forever_coreclk", {3'b000, fclk}, 4'h1);
                @(negedge clk);
                #1;
                chk("dom_clk_low", dclk, 4'h0);
            end
        end
    end

    initial begin
        logic [NS-1:0] w_int;
        logic [NS-1:0] w_norm;
        logic [NS-1:0] w_snoop;
        logic [NS-1:0] w;
        int            wait_cyc;
        int            quiet;

        map_v   = MAP;
        w_int   = '0; w_int[SRC_INT] = 1'b1;
        w_norm  = '0; w_norm[SRC_NORMAL] = 1'b1;
        w_snoop = '0; w_snoop[SRC_SNOOP] = 1'b1;
        for (int d = 0; d < ND; d++) begin
            m_off[d] = 1'b0; m_idle[d] = 0; m_settle[d] = 0;
        end

        // Reset held, then released with everything idle
        repeat (5) begin
            step('0, '0, 1'b0, 1'b0, 1'b1);
            sync();
            chk("t1_rst_on", don, 4'hF);
            chk("t1_rst_req", dreq, 4'h0);
        end
        repeat (16) step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t1_req_early", dreq, 4'h0);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t1_req_at16", dreq, 4'hF);
        repeat (3) step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t1_req_held", dreq, 4'hF);

        // Ack domain 0 only
        step('0, 4'b0001, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t2_on", don, 4'hE);
        chk("t2_req", dreq, 4'hE);
        step('0, '0, 1'b0, 1'b0, 1'b0);

        // One-cycle wake pulse on source 1
        step(w_int, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t3_wake0", don, 4'hE);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t3_wake1", don, 4'hE);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t3_settled", don, 4'hF);
        repeat (20) step('0, '0, 1'b0, 1'b0, 1'b0);

        // Wake in HOLD at count 10 restarts the hysteresis
        step(w_norm, '0, 1'b0, 1'b0, 1'b0);
        repeat (11) step('0, '0, 1'b0, 1'b0, 1'b0);
        step(w_norm, '0, 1'b0, 1'b0, 1'b0);
        repeat (7) step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t4_no_early_req", dreq, 4'h0);
        repeat (9) step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t4_req_pre", dreq, 4'h0);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t4_req_at16", dreq, 4'hF);

        // Ack and debug force in the same cycle: wake wins
        step('0, 4'hF, 1'b0, 1'b1, 1'b0);
        sync();
        chk("t5_req", dreq, 4'h0);
        chk("t5_on", don, 4'hF);

        // Park domain 2 in OFF and toggle a source it does not listen to
        repeat (17) step('0, '0, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t6_qreq", dreq, 4'hF);
        step('0, 4'b0100, 1'b0, 1'b0, 1'b0);
        sync();
        chk("t6_off", don, 4'hB);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        glitch_win = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step((i % 2 == 0) ? w_snoop : '0, '0, 1'b0, 1'b0, 1'b0);
            sync();
            chk("t6_dom2_off", {3'b000, don[2]}, 4'h0);
        end
        glitch_win = 1'b0;
        chk("t6_no_glitch", (glitch_cnt > 15) ? 4'hF : 4'(glitch_cnt), 4'h0);
        step('0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t6_rst_async_on", {3'b000, don[2]}, 4'h1);
        step('0, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with alternating quiet and busy segments
        for (int seg = 0; seg < 20; seg++) begin
            quiet = int'($urandom_range(0, 1));
            for (int i = 0; i < 30; i++) begin
                for (int s = 0; s < NS; s++) begin
                    w[s] = ($urandom_range(0, (quiet != 0) ? 200 : 12) == 0);
                end
                step(w, 4'($urandom()),
                     ($urandom_range(0, 150) == 0),
                     ($urandom_range(0, 150) == 0),
                     ($urandom_range(0, 400) == 0));
            end
        end
        step('0, '0, 1'b0, 1'b0, 1'b0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
